lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: accepts one execute-stage op at a time, issues at most one
// memory request, and presents the writeback result on a valid/ready port.
module lsu #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  e_regW,
  input  logic [ADDR_WIDTH-1:0] e_regAddr,
  input  logic [DATA_WIDTH-1:0] e_regData,
  input  logic [2:0]            e_load_inst,
  input  logic [3:0]            e_store_mask,
  input  logic [DATA_WIDTH-1:0] e_store_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [3:0]            mem_wmask,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_regW,
  output logic [ADDR_WIDTH-1:0] m_regAddr,
  output logic [DATA_WIDTH-1:0] m_regData,
  output logic                  m_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LW  = 3'd5;

  state_t state_q, state_d;

  logic                  in_fire;
  logic                  in_is_load;
  logic                  in_is_store;
  logic                  in_half;
  logic                  in_word;
  logic                  in_misalign;
  logic [1:0]            in_off;

  logic [2:0]            ld_q;
  logic [1:0]            off_q;
  logic [DATA_WIDTH-1:0] mem_addr_q;
  logic                  mem_wen_q;
  logic [3:0]            mem_wmask_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  m_regW_q;
  logic [ADDR_WIDTH-1:0] m_regAddr_q;
  logic [DATA_WIDTH-1:0] m_regData_q;
  logic                  m_misalign_q;

  logic [DATA_WIDTH-1:0] rsp_shifted;
  logic [DATA_WIDTH-1:0] load_ext;

  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign m_valid       = (state_q == DONE);
  assign in_fire       = in_valid && in_ready;
  assign in_off        = e_regData[1:0];

  assign mem_addr   = mem_addr_q;
  assign mem_wen    = mem_wen_q;
  assign mem_wmask  = mem_wmask_q;
  assign mem_wdata  = mem_wdata_q;
  assign m_regW     = m_regW_q;
  assign m_regAddr  = m_regAddr_q;
  assign m_regData  = m_regData_q;
  assign m_misalign = m_misalign_q;

  // Decode the incoming op: loads win over stores, sizes drive the alignment check
  always_comb begin
    in_is_load  = (e_load_inst >= LD_LB) && (e_load_inst <= LD_LW);
    in_is_store = !in_is_load && (e_store_mask != 4'b0000);
    in_half     = (in_is_load && (e_load_inst == LD_LH || e_load_inst == LD_LHU)) ||
                  (in_is_store && e_store_mask == 4'b0011);
    in_word     = (in_is_load && e_load_inst == LD_LW) ||
                  (in_is_store && e_store_mask == 4'b1111);
    in_misalign = (in_half && in_off[0]) || (in_word && (in_off != 2'b00));
  end

  // Select and extend the addressed bytes of the read response
  always_comb begin
    rsp_shifted = mem_rdata >> {off_q, 3'b000};
    load_ext    = rsp_shifted;
    case (ld_q)
      LD_LB:   load_ext = {{(DATA_WIDTH-8){rsp_shifted[7]}}, rsp_shifted[7:0]};
      LD_LBU:  load_ext = {{(DATA_WIDTH-8){1'b0}}, rsp_shifted[7:0]};
      LD_LH:   load_ext = {{(DATA_WIDTH-16){rsp_shifted[15]}}, rsp_shifted[15:0]};
      LD_LHU:  load_ext = {{(DATA_WIDTH-16){1'b0}}, rsp_shifted[15:0]};
      default: load_ext = rsp_shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          if ((in_is_load || in_is_store) && !in_misalign) state_d = REQ;
          else                                             state_d = DONE;
        end
      end
      REQ:  if (mem_req_ready) state_d = mem_wen_q ? DONE : WAIT;
      WAIT: if (mem_rsp_valid) state_d = DONE;
      DONE: if (m_ready)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the op and request payload on acceptance; capture load data in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_q         <= '0;
      off_q        <= '0;
      mem_addr_q   <= '0;
      mem_wen_q    <= 1'b0;
      mem_wmask_q  <= '0;
      mem_wdata_q  <= '0;
      m_regW_q     <= 1'b0;
      m_regAddr_q  <= '0;
      m_regData_q  <= '0;
      m_misalign_q <= 1'b0;
    end else if (in_fire) begin
      ld_q         <= in_is_load ? e_load_inst : 3'd0;
      off_q        <= in_off;
      mem_addr_q   <= {e_regData[DATA_WIDTH-1:2], 2'b00};
      mem_wen_q    <= in_is_store;
      mem_wmask_q  <= in_is_store ? (e_store_mask << in_off) : 4'b0000;
      mem_wdata_q  <= in_is_store ? (e_store_data << {in_off, 3'b000}) : '0;
      m_regW_q     <= e_regW && !in_misalign;
      m_regAddr_q  <= e_regAddr;
      m_regData_q  <= e_regData;
      m_misalign_q <= in_misalign;
    end else if (state_q == WAIT && mem_rsp_valid) begin
      m_regData_q  <= load_ext;
    end
  end

endmodule
